// File: rtl/ipdc_pkg.sv
// Shared constants, op modes and FSM encoding for the ipdc feeder slice.
package ipdc_pkg;

  localparam int OP_W      = 4;
  localparam int DATA_W    = 24;
  localparam int PIX_NUM   = 256;
  localparam int PIX_AW    = 8;
  localparam int CMD_DEPTH = 8;
  localparam int CMD_AW    = 3;

  localparam logic [CMD_AW:0]   CMD_FULL = 4'd8;
  localparam logic [PIX_AW-1:0] PIX_LAST = 8'(PIX_NUM - 1);

  localparam logic [OP_W-1:0] OP_LOAD = 4'd0;
  localparam logic [OP_W-1:0] LOAD_OP = OP_LOAD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_LOAD    = 2'd2,
    ST_WAIT_LO = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/ipdc_skid_fifo.sv
// Two-entry valid/ready buffer for the pixel path; the head stays put until popped.
module ipdc_skid_fifo
  import ipdc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occupancy,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        occ_r;
  logic              pop_ok_s;
  logic              push_ok_s;

  assign pop_ok_s  = pop && (occ_r != 2'd0);
  assign push_ok_s = push && ((occ_r != 2'd2) || pop_ok_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= {DATA_W{1'b0}};
      mem_r[1] <= {DATA_W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
    end
  end

  assign occupancy  = occ_r;
  assign head_valid = (occ_r != 2'd0);
  assign head_data  = mem_r[rd_ptr_r];

endmodule

// File: rtl/ipdc_feeder.sv
// Command queue plus issue/load FSM that feeds ops and a 256-pixel image into ipdc.
module ipdc_feeder
  import ipdc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  input  logic [OP_W-1:0]   i_cmd_op,
  output logic              o_cmd_ready,
  output logic              o_pix_rd,
  output logic [PIX_AW-1:0] o_pix_addr,
  input  logic [DATA_W-1:0] i_pix_data,
  input  logic              i_op_ready,
  output logic              o_op_valid,
  output logic [OP_W-1:0]   o_op_mode,
  input  logic              i_in_ready,
  output logic              o_in_valid,
  output logic [DATA_W-1:0] o_in_data,
  output logic              o_busy,
  output logic              o_load_done
);

  logic [OP_W-1:0]   cmd_mem_r [CMD_DEPTH];
  logic [CMD_AW-1:0] cmd_wr_ptr_r;
  logic [CMD_AW-1:0] cmd_rd_ptr_r;
  logic [CMD_AW:0]   cmd_count_r;
  feeder_state_e     state_r;
  feeder_state_e     state_nxt_s;
  logic [OP_W-1:0]   cur_op_r;
  logic [PIX_AW-1:0] addr_r;
  logic              reads_done_r;
  logic              inflight_r;
  logic [PIX_AW-1:0] xfer_cnt_r;
  logic              load_done_r;

  logic              push_s;
  logic              pop_s;
  logic              rd_s;
  logic              xfer_s;
  logic              last_xfer_s;
  logic [1:0]        occ_s;
  logic              fifo_valid_s;
  logic [DATA_W-1:0] fifo_data_s;

  assign o_cmd_ready = (cmd_count_r != CMD_FULL);
  assign push_s      = i_cmd_valid && o_cmd_ready;
  assign pop_s       = (state_r == ST_IDLE) && (cmd_count_r != 4'd0) && i_op_ready;
  assign xfer_s      = o_in_valid && i_in_ready;
  assign last_xfer_s = xfer_s && (xfer_cnt_r == PIX_LAST);

  // Credit check: buffered + in-flight words, less the one leaving now, must leave room
  assign rd_s = (state_r == ST_LOAD) && !reads_done_r &&
                (({1'b0, occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, xfer_s}));

  // Command queue storage and head capture on pop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < CMD_DEPTH; i++) begin
        cmd_mem_r[i] <= {OP_W{1'b0}};
      end
      cmd_wr_ptr_r <= {CMD_AW{1'b0}};
      cmd_rd_ptr_r <= {CMD_AW{1'b0}};
      cmd_count_r  <= {(CMD_AW+1){1'b0}};
      cur_op_r     <= {OP_W{1'b0}};
    end else begin
      if (push_s) begin
        cmd_mem_r[cmd_wr_ptr_r] <= i_cmd_op;
        cmd_wr_ptr_r            <= cmd_wr_ptr_r + 3'd1;
      end
      if (pop_s) begin
        cur_op_r     <= cmd_mem_r[cmd_rd_ptr_r];
        cmd_rd_ptr_r <= cmd_rd_ptr_r + 3'd1;
      end
      case ({push_s, pop_s})
        2'b10:   cmd_count_r <= cmd_count_r + 4'd1;
        2'b01:   cmd_count_r <= cmd_count_r - 4'd1;
        default: cmd_count_r <= cmd_count_r;
      endcase
    end
  end

  // Pixel address/transfer counters, re-armed in the ISSUE cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_r       <= {PIX_AW{1'b0}};
      reads_done_r <= 1'b0;
      inflight_r   <= 1'b0;
      xfer_cnt_r   <= {PIX_AW{1'b0}};
      load_done_r  <= 1'b0;
    end else begin
      if (state_r == ST_ISSUE) begin
        addr_r       <= {PIX_AW{1'b0}};
        reads_done_r <= 1'b0;
        xfer_cnt_r   <= {PIX_AW{1'b0}};
      end else begin
        if (rd_s) begin
          if (addr_r == PIX_LAST) begin
            reads_done_r <= 1'b1;
          end else begin
            addr_r <= addr_r + 8'd1;
          end
        end
        if (xfer_s) begin
          xfer_cnt_r <= xfer_cnt_r + 8'd1;
        end
      end
      inflight_r  <= rd_s;
      load_done_r <= last_xfer_s;
    end
  end

  ipdc_skid_fifo u_skid (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (inflight_r),
    .push_data  (i_pix_data),
    .pop        (xfer_s),
    .occupancy  (occ_s),
    .head_valid (fifo_valid_s),
    .head_data  (fifo_data_s)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_nxt_s = ST_ISSUE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (cur_op_r == LOAD_OP) state_nxt_s = ST_LOAD;
        else                     state_nxt_s = ST_WAIT_LO;
      end
      ST_LOAD: begin
        if (last_xfer_s) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_LOAD;
      end
      ST_WAIT_LO: begin
        if (!i_op_ready) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_WAIT_LO;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from registered state
  always_comb begin
    o_op_valid = 1'b0;
    o_op_mode  = {OP_W{1'b0}};
    case (state_r)
      ST_ISSUE: begin
        o_op_valid = 1'b1;
        o_op_mode  = cur_op_r;
      end
      default: begin
        o_op_valid = 1'b0;
        o_op_mode  = {OP_W{1'b0}};
      end
    endcase
  end

  assign o_busy      = (state_r != ST_IDLE) || (cmd_count_r != 4'd0);
  assign o_pix_rd    = rd_s;
  assign o_pix_addr  = addr_r;
  assign o_in_valid  = (state_r == ST_LOAD) && fifo_valid_s;
  assign o_in_data   = o_in_valid ? fifo_data_s : {DATA_W{1'b0}};
  assign o_load_done = load_done_r;

endmodule
